// File: rtl/iccm_loader.sv
// Packs a UART byte stream little-endian into 32-bit words, writes them to the ICCM and
// releases the program reset on the end-of-program marker. Optional macro: ICCM_LOADER_TIMEOUT_EN.
module iccm_loader #(
    parameter int unsigned AddrW         = 12,
    parameter logic [31:0] EndWord       = 32'h0000_0FFF,
    parameter int unsigned TimeoutCycles = 1000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_dv_i,
    input  logic [7:0]       rx_byte_i,
    output logic             we_o,
    output logic [AddrW-1:0] addr_o,
    output logic [31:0]      wdata_o,
    output logic             prog_rst_no,
    output logic             done_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StProg,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [23:0]        asm_q, asm_d;
    logic               we_q, we_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               prog_rst_q, prog_rst_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

`ifdef ICCM_LOADER_TIMEOUT_EN
    localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               wrote_q, wrote_d;
`else
    // Timeout depth only matters when the timeout feature is built in.
    if (TimeoutCycles == 0) begin : g_no_timeout_cfg
    end
`endif

    // Next-state, byte packing and write sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        prog_rst_d = prog_rst_q;
        done_d     = done_q;
        ovf_d      = ovf_q;

        case (state_q)
            StIdle: begin
                if (rx_dv_i) begin
                    asm_d   = {16'h0000, rx_byte_i};
                    cnt_d   = 2'd1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (rx_dv_i) begin
                    if (cnt_q == 2'd3) begin
                        wdata_d = {rx_byte_i, asm_q};
                        we_d    = ({rx_byte_i, asm_q} != EndWord);
                        asm_d   = 24'h000000;
                        cnt_d   = 2'd0;
                        state_d = StProg;
                    end else begin
                        case (cnt_q)
                            2'd0:    asm_d[7:0]   = rx_byte_i;
                            2'd1:    asm_d[15:8]  = rx_byte_i;
                            default: asm_d[23:16] = rx_byte_i;
                        endcase
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StProg: begin
                if (wdata_q == EndWord) begin
                    state_d    = StDone;
                    prog_rst_d = 1'b1;
                    done_d     = 1'b1;
                end else if (addr_q == {AddrW{1'b1}}) begin
                    // Last location written: stop without wrapping the address.
                    ovf_d      = 1'b1;
                    state_d    = StDone;
                    prog_rst_d = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    addr_d  = addr_q + AddrW'(1);
                    state_d = StLoad;
                    if (rx_dv_i) begin
                        asm_d = {16'h0000, rx_byte_i};
                        cnt_d = 2'd1;
                    end
                end
            end
            default: begin
            end
        endcase

`ifdef ICCM_LOADER_TIMEOUT_EN
        wrote_d = wrote_q | we_q;
        tmo_d   = tmo_q;
        if (rx_dv_i || (cnt_q == 2'd0) || (state_q != StLoad)) begin
            tmo_d = '0;
        end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
            // Stalled partial word: drop it and wait for a fresh word at the same address.
            tmo_d   = '0;
            cnt_d   = 2'd0;
            asm_d   = 24'h000000;
            state_d = wrote_q ? StLoad : StIdle;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            asm_q      <= 24'h000000;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0000_0000;
            prog_rst_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            prog_rst_q <= prog_rst_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef ICCM_LOADER_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q   <= '0;
            wrote_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            wrote_q <= wrote_d;
        end
    end
`endif

    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign prog_rst_no = prog_rst_q;
    assign done_o      = done_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_iccm_loader.sv
// Directed + randomized bench for iccm_loader against a byte-queue reference model.
module tb_iccm_loader;

    localparam int unsigned AW  = 4;
    localparam int unsigned TMO = 16;
    localparam logic [31:0] END_WORD = 32'h0000_0FFF;

    logic          clk;
    logic          rst_n;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic          prog_rst_no;
    logic          done_o;
    logic          overflow_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    logic [7:0] m_part[$];
    int         m_addr;
    bit         m_done;
    bit         m_ovf;
    int         m_last;

    iccm_loader #(
        .AddrW        (AW),
        .EndWord      (END_WORD),
        .TimeoutCycles(TMO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_dv_i    (rx_dv),
        .rx_byte_i  (rx_byte),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .prog_rst_no(prog_rst_no),
        .done_o     (done_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_reset();
        m_part.delete();
        m_addr = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_last = -1000;
    endtask

    // Byte accepted at cycle acc; returns whether that byte completes a memory write.
    task automatic model_byte(input logic [7:0] b, input int acc,
                              output bit exp_we, output int exp_a, output logic [31:0] exp_w);
        exp_we = 1'b0;
        exp_a  = 0;
        exp_w  = 32'h0;
        if (m_done) return;
`ifdef ICCM_LOADER_TIMEOUT_EN
        if (m_part.size() > 0 && (acc - m_last - 1) >= TMO) m_part.delete();
`endif
        m_last = acc;
        m_part.push_back(b);
        if (m_part.size() == 4) begin
            exp_w = {m_part[3], m_part[2], m_part[1], m_part[0]};
            m_part.delete();
            if (exp_w == END_WORD) begin
                m_done = 1'b1;
            end else begin
                exp_we = 1'b1;
                exp_a  = m_addr;
                if (m_addr == (1 << AW) - 1) begin
                    m_ovf  = 1'b1;
                    m_done = 1'b1;
                end else begin
                    m_addr++;
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit          exp_we;
        int          exp_a;
        logic [31:0] exp_w;
        model_byte(b, cyc + 1, exp_we, exp_a, exp_w);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom);
        check("we_after_byte", 64'(we_o), 64'(exp_we));
        if (exp_we) begin
            check("write_addr", 64'(addr_o), 64'(exp_a));
            check("write_data", 64'(wdata_o), 64'(exp_w));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("we_idle", 64'(we_o), 64'd0);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        model_reset();
        tick();
        check("rst_we", 64'(we_o), 64'd0);
        check("rst_addr", 64'(addr_o), 64'd0);
        check("rst_wdata", 64'(wdata_o), 64'd0);
        check("rst_prog_rst", 64'(prog_rst_no), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        tick();
        rst_n = 1'b1;
        idle(5);
        check("idle_prog_rst", 64'(prog_rst_no), 64'd0);
        check("idle_addr", 64'(addr_o), 64'd0);

        // Two words then the marker.
        send_word(32'h0000_0513);
        check("w0_data", 64'(wdata_o), 64'h0000_0513);
        idle(2);
        send_word(32'h00A0_0093);
        check("w1_addr", 64'(addr_o), 64'd1);
        idle(1);
        send_word(END_WORD);
        check("marker_prog_cycle_prog_rst", 64'(prog_rst_no), 64'd0);
        tick();
        check("marker_prog_rst", 64'(prog_rst_no), 64'd1);
        check("marker_done", 64'(done_o), 64'd1);
        check("marker_ovf", 64'(overflow_o), 64'd0);
        for (int i = 0; i < 8; i++) send(8'(i * 37 + 5));
        check("done_addr_hold", 64'(addr_o), 64'd2);
        check("done_sticky", 64'(done_o), 64'd1);

        // Back-to-back bytes across the PROG cycle.
        pulse_reset();
        check("rerst_done", 64'(done_o), 64'd0);
        check("rerst_prog_rst", 64'(prog_rst_no), 64'd0);
        for (int i = 1; i <= 8; i++) send(8'(i));
        idle(2);
        check("b2b_addr", 64'(addr_o), 64'd2);
        check("b2b_last_data", 64'(wdata_o), 64'h0807_0605);

        // Reset mid-word discards the partial word and the address.
        send(8'h55);
        send(8'h66);
        pulse_reset();
        check("midrst_addr", 64'(addr_o), 64'd0);
        send_word(32'hDEAD_BEEF);
        check("deadbeef_data", 64'(wdata_o), 64'hDEAD_BEEF);
        idle(1);

        // Stalled partial word.
        pulse_reset();
        send(8'hAA);
        send(8'hBB);
        idle(16);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        idle(1);
`ifdef ICCM_LOADER_TIMEOUT_EN
        check("timeout_word", 64'(wdata_o), 64'h4433_2211);
`else
        check("no_timeout_word", 64'(wdata_o), 64'h2211_BBAA);
`endif
        check("timeout_addr", 64'(addr_o), 64'd1);

        // Random stream with random gaps, running through the last address.
        pulse_reset();
        for (int i = 0; i < 90; i++) begin
            idle(($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 2)));
            send(8'($urandom));
        end
        idle(3);
        check("rand_done", 64'(done_o), 64'(m_done));
        check("rand_prog_rst", 64'(prog_rst_no), 64'(m_done));
        check("rand_ovf", 64'(overflow_o), 64'(m_ovf));
        check("rand_addr", 64'(addr_o), 64'(m_addr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
